branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Direction and target predictor that sits directly upstream of the fetch-stage PC mux and feeds the branch-predict record consumed by fetch and the predict-statistics monitor. It gives a same-cycle prediction (taken flag, next-PC-valid flag, predicted next PC) for the current fetch PC. It is trained one branch per cycle from the execute-stage resolution port. It uses a pattern history table (PHT) of 2-bit saturating counters and a direct-mapped branch target buffer (BTB).

Parameters:
PC_WIDTH, 32, fetch/branch PC width in bits
PHT_INDEX_BITS, 6, log2 of PHT entries (64)
BTB_INDEX_BITS, 5, log2 of BTB entries (32)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
fetchPc  input  PC_WIDTH  PC being fetched this cycle
predTaken  output  1  predicted direction (maps to isBranchTakenPredicted)
predNextPcValid  output  1  BTB hit for fetchPc (maps to isNextPcPredicted)
predNextPc  output  PC_WIDTH  predicted next PC (maps to predictedNextPC)
updValid  input  1  resolved branch present this cycle
updPc  input  PC_WIDTH  PC of the resolved branch
updTaken  input  1  actual direction
updTarget  input  PC_WIDTH  actual taken target

Behaviour:
- Reset is decided: rst is synchronous and active-high; clk is the clock. All state changes happen on posedge clk.
- Reset action: every PHT counter is set to 2'b01 (weakly not-taken). Every BTB valid bit is cleared; BTB tags and targets are don't-care. While rst=1, the update port is ignored.
- Outputs while rst=1: predTaken=0, predNextPcValid=0, predNextPc=fetchPc+4.
- PHT index: phtIdx = fetchPc[PHT_INDEX_BITS+1:2] for lookup and updPc[PHT_INDEX_BITS+1:2] for update. Bits [1:0] are ignored.
- BTB index: fetchPc[BTB_INDEX_BITS+1:2].
- BTB tag: fetchPc[PC_WIDTH-1:BTB_INDEX_BITS+2].
- btbHit = valid[idx] AND (tag[idx] == lookup tag).
- Lookup is combinational with zero latency:
  - predTaken = PHT[phtIdx][1].
  - predNextPcValid = btbHit.
  - predNextPc = BTB target if predTaken AND btbHit; otherwise fetchPc+4.
  - Taken with a BTB miss gives predTaken=1, predNextPcValid=0, predNextPc=fetchPc+4.
- fetchPc+4 is computed modulo 2^PC_WIDTH; it wraps to 0 from 0xFFFFFFFC.
- Update takes effect on the posedge where updValid=1 and rst=0:
  - PHT counter: if updTaken, increment, saturating at 2'b11; otherwise decrement, saturating at 2'b00.
  - BTB, if updTaken: write valid=1, tag and target=updTarget at the updPc index. This overwrites any aliasing entry.
  - BTB, if not taken: unchanged.
- Same-cycle lookup and update to the same entry: lookup returns the pre-update value, with no bypass. The new value is visible on the next cycle.
- Only one update per cycle. Updates are in program order and non-speculative.
- There is no handshake and no stall. The block never back-pressures.

Optional Feature:
Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Defined:
  - A PHT_INDEX_BITS-wide global history register (GHR) is added; it resets to 0.
  - On each valid update, GHR <= {GHR[PHT_INDEX_BITS-2:0], updTaken}.
  - Lookup index = fetchPc index bits XOR GHR.
  - Update index = updPc index bits XOR the GHR value before the shift.
  - GHR is updated at resolution only; there is no speculative history or repair.
- Undefined: the PHT is bimodal, indexed by PC bits only, and no GHR exists.

Test Plan:
- Reset, then fetchPc=0x100 -> predTaken=0, predNextPcValid=0, predNextPc=0x104.
- Two updates (updPc=0x100, updTaken=1, updTarget=0x200), then fetchPc=0x100 -> counter=11, predTaken=1, predNextPcValid=1, predNextPc=0x200.
- From counter 11, three not-taken updates on 0x100 -> counter saturates at 00, predTaken=0, predNextPc=0x104. BTB still hits, so predNextPcValid=1.
- Alias check: after training 0x100 taken to 0x200, one taken update on 0x180 (same BTB index, different tag) to 0x300. Then fetchPc=0x100 -> predNextPcValid=0, predNextPc=0x104; fetchPc=0x180 -> target 0x300 once its counter is 1x.
- Same-cycle collision: fetchPc=updPc=0x40 with counter 01 and updTaken=1 -> predTaken=0 that cycle; predTaken=1 on the next cycle.
- Wrap and reset: fetchPc=0xFFFFFFFC not-taken -> predNextPc=0x0. Assert rst mid-stream after training -> next cycle all lookups are not-taken and BTB misses. With BRANCH_PREDICTOR_GSHARE_EN, GHR=0 after reset.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch direction and target predictor for the fetch stage.
//
// Lookup is purely combinational on fetchPc: a table of 2-bit saturating
// counters supplies the direction, and a direct-mapped branch target buffer
// supplies the target. Training arrives one resolved branch per cycle from
// execute and is written on the clock edge, so a lookup in the same cycle as
// an update to the same entry sees the old contents (no bypass).
//
// Optional build macro: BRANCH_PREDICTOR_GSHARE_EN
//   When defined, a global history register of PHT_INDEX_BITS bits is XORed
//   into the counter-table index (gshare). History advances only at
//   resolution; there is no speculative history or repair. When undefined,
//   the counter table is bimodal and indexed by PC bits alone.

module branch_predictor #(
    parameter int PC_WIDTH       = 32,
    parameter int PHT_INDEX_BITS = 6,
    parameter int BTB_INDEX_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] fetchPc,
    output logic                predTaken,
    output logic                predNextPcValid,
    output logic [PC_WIDTH-1:0] predNextPc,
    input  logic                updValid,
    input  logic [PC_WIDTH-1:0] updPc,
    input  logic                updTaken,
    input  logic [PC_WIDTH-1:0] updTarget
);

    localparam int PHT_ENTRIES = 1 << PHT_INDEX_BITS;
    localparam int BTB_ENTRIES = 1 << BTB_INDEX_BITS;
    localparam int TAG_WIDTH   = PC_WIDTH - BTB_INDEX_BITS - 2;

    // Next counter value after one resolved outcome, saturating at both ends.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) begin
                nxt = ctr + 2'b01;
            end else begin
                nxt = ctr;
            end
        end else begin
            if (ctr != 2'b00) begin
                nxt = ctr - 2'b01;
            end else begin
                nxt = ctr;
            end
        end
        return nxt;
    endfunction

    // Prediction state
    logic [1:0]           pht [PHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_WIDTH-1:0] btb_tag [BTB_ENTRIES];
    logic [PC_WIDTH-1:0]  btb_target [BTB_ENTRIES];

    // Index / tag extraction; the two byte-offset bits of a PC never matter.
    logic [PHT_INDEX_BITS-1:0] look_pht_idx;
    logic [PHT_INDEX_BITS-1:0] upd_pht_idx;
    logic [BTB_INDEX_BITS-1:0] look_btb_idx;
    logic [BTB_INDEX_BITS-1:0] upd_btb_idx;
    logic [TAG_WIDTH-1:0]      look_tag;
    logic [TAG_WIDTH-1:0]      upd_tag;
    logic                      upd_pc_unused;

    assign look_btb_idx  = fetchPc[BTB_INDEX_BITS+1:2];
    assign upd_btb_idx   = updPc[BTB_INDEX_BITS+1:2];
    assign look_tag      = fetchPc[PC_WIDTH-1:BTB_INDEX_BITS+2];
    assign upd_tag       = updPc[PC_WIDTH-1:BTB_INDEX_BITS+2];
    assign upd_pc_unused = ^updPc[1:0];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [PHT_INDEX_BITS-1:0] ghr;

    // Both lookup and update hash with the history as it stands before this
    // cycle's resolution shifts in.
    assign look_pht_idx = fetchPc[PHT_INDEX_BITS+1:2] ^ ghr;
    assign upd_pht_idx  = updPc[PHT_INDEX_BITS+1:2] ^ ghr;

    // Global history shifts in each resolved outcome, newest in the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= {PHT_INDEX_BITS{1'b0}};
        end else if (updValid) begin
            ghr <= {ghr[PHT_INDEX_BITS-2:0], updTaken};
        end else begin
            ghr <= ghr;
        end
    end
`else
    assign look_pht_idx = fetchPc[PHT_INDEX_BITS+1:2];
    assign upd_pht_idx  = updPc[PHT_INDEX_BITS+1:2];
`endif

    // Counter table: reset to weakly not-taken, then train on every resolution.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (updValid) begin
            pht[upd_pht_idx] <= sat_update(pht[upd_pht_idx], updTaken);
        end else begin
            pht[upd_pht_idx] <= pht[upd_pht_idx];
        end
    end

    // BTB valid bits: cleared on reset, set by any taken resolution.
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= {BTB_ENTRIES{1'b0}};
        end else if (updValid && updTaken) begin
            btb_valid[upd_btb_idx] <= 1'b1;
        end else begin
            btb_valid <= btb_valid;
        end
    end

    // BTB tag/target payload; contents are meaningless until valid, so no reset.
    // A taken branch simply overwrites whatever aliased into its slot.
    always_ff @(posedge clk) begin
        if (!rst && updValid && updTaken) begin
            btb_tag[upd_btb_idx]    <= upd_tag;
            btb_target[upd_btb_idx] <= updTarget;
        end
    end

    // Same-cycle lookup; forced to a not-taken sequential prediction in reset.
    logic                btb_hit;
    logic                ctr_taken;
    logic [PC_WIDTH-1:0] seq_pc;

    assign seq_pc = fetchPc + PC_WIDTH'(32'd4);

    always_comb begin
        btb_hit         = 1'b0;
        ctr_taken       = 1'b0;
        predTaken       = 1'b0;
        predNextPcValid = 1'b0;
        predNextPc      = seq_pc;
        if (rst) begin
            predTaken       = 1'b0;
            predNextPcValid = 1'b0;
            predNextPc      = seq_pc;
        end else begin
            btb_hit         = btb_valid[look_btb_idx] && (btb_tag[look_btb_idx] == look_tag);
            ctr_taken       = pht[look_pht_idx][1];
            predTaken       = ctr_taken;
            predNextPcValid = btb_hit;
            if (ctr_taken && btb_hit) begin
                predNextPc = btb_target[look_btb_idx];
            end else begin
                predNextPc = seq_pc;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// random traffic, all compared against a behavioural reference model.

module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetchPc;
    logic        predTaken;
    logic        predNextPcValid;
    logic [31:0] predNextPc;
    logic        updValid;
    logic [31:0] updPc;
    logic        updTaken;
    logic [31:0] updTarget;

    int tests = 0;
    int fails = 0;

    branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .fetchPc         (fetchPc),
        .predTaken       (predTaken),
        .predNextPcValid (predNextPcValid),
        .predNextPc      (predNextPc),
        .updValid        (updValid),
        .updPc           (updPc),
        .updTaken        (updTaken),
        .updTarget       (updTarget)
    );

    always #5 clk = ~clk;

    // Reference model: counters as plain integers 0..3, BTB keyed by word index.
    int          m_cnt [64];
    bit          m_val [32];
    int unsigned m_tag [32];
    logic [31:0] m_tgt [32];
    int          m_hist;

    function automatic int pht_slot(input logic [31:0] pc);
        int s;
        s = int'((pc / 32'd4) % 32'd64);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        s = s ^ m_hist;
`endif
        return s;
    endfunction

    function automatic int btb_slot(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd32);
    endfunction

    function automatic int unsigned btb_key(input logic [31:0] pc);
        return int'(pc / 32'd128);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 1;
        for (int i = 0; i < 32; i++) m_val[i] = 1'b0;
        m_hist = 0;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        int s;
        s = pht_slot(pc);
        if (tk) m_cnt[s] = (m_cnt[s] < 3) ? m_cnt[s] + 1 : 3;
        else    m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
        if (tk) begin
            m_val[btb_slot(pc)] = 1'b1;
            m_tag[btb_slot(pc)] = btb_key(pc);
            m_tgt[btb_slot(pc)] = tgt;
        end
        m_hist = (m_hist * 2 + int'(tk)) % 64;
    endtask

    // One clock: drive inputs after negedge, check lookup, then advance model.
    task automatic step(input logic r, input logic [31:0] fpc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                        input string tag);
        logic        et;
        logic        ev;
        logic [31:0] en;
        int          b;
        @(negedge clk);
        rst = r; fetchPc = fpc; updValid = uv; updPc = upc; updTaken = ut; updTarget = utg;
        #1;
        en = fpc + 32'd4;
        if (r) begin
            et = 1'b0;
            ev = 1'b0;
        end else begin
            b  = btb_slot(fpc);
            et = (m_cnt[pht_slot(fpc)] >= 2);
            ev = m_val[b] && (m_tag[b] == btb_key(fpc));
            if (et && ev) en = m_tgt[b];
        end
        tests++;
        assert (predTaken === et) else begin
            fails++;
            $error("FAIL %s predTaken pc=%h got=%b exp=%b", tag, fpc, predTaken, et);
        end
        tests++;
        assert (predNextPcValid === ev) else begin
            fails++;
            $error("FAIL %s predNextPcValid pc=%h got=%b exp=%b", tag, fpc, predNextPcValid, ev);
        end
        tests++;
        assert (predNextPc === en) else begin
            fails++;
            $error("FAIL %s predNextPc pc=%h got=%h exp=%h", tag, fpc, predNextPc, en);
        end
        if (r) model_reset();
        else if (uv) model_update(upc, ut, utg);
    endtask

    task automatic look(input logic [31:0] fpc, input string tag);
        step(1'b0, fpc, 1'b0, 32'h0, 1'b0, 32'h0, tag);
    endtask

    task automatic train(input logic [31:0] upc, input logic ut, input logic [31:0] utg);
        step(1'b0, 32'h0000_0800, 1'b1, upc, ut, utg, "train");
    endtask

    logic [31:0] rpc;
    logic [31:0] rfp;

    initial begin
        rst = 1'b1; fetchPc = 32'h0; updValid = 1'b0; updPc = 32'h0;
        updTaken = 1'b0; updTarget = 32'h0;
        model_reset();

        // Reset, with an update present that must be ignored
        step(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, "in_reset");
        step(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b0, 32'h0, "in_reset2");
        look(32'h0000_0100, "post_reset");

        // Two taken updates -> strongly taken with BTB hit
        train(32'h0000_0100, 1'b1, 32'h0000_0200);
        train(32'h0000_0100, 1'b1, 32'h0000_0200);
        look(32'h0000_0100, "trained_taken");
`ifndef BRANCH_PREDICTOR_GSHARE_EN
        tests++;
        assert (predNextPc === 32'h0000_0200) else begin
            fails++;
            $error("FAIL plan_target got=%h exp=%h", predNextPc, 32'h0000_0200);
        end
`endif

        // Three not-taken -> saturate at 00, BTB entry still valid
        train(32'h0000_0100, 1'b0, 32'h0);
        train(32'h0000_0100, 1'b0, 32'h0);
        train(32'h0000_0100, 1'b0, 32'h0);
        look(32'h0000_0100, "saturated_nt");
        train(32'h0000_0100, 1'b1, 32'h0000_0200);
        look(32'h0000_0100, "from_00_one_taken");

        // Aliasing BTB entry overwrite
        train(32'h0000_0100, 1'b1, 32'h0000_0200);
        train(32'h0000_0180, 1'b1, 32'h0000_0300);
        look(32'h0000_0100, "alias_evicted");
        look(32'h0000_0180, "alias_weak");
        train(32'h0000_0180, 1'b1, 32'h0000_0300);
        look(32'h0000_0180, "alias_target");

        // Same-cycle lookup and update: no bypass
        step(1'b0, 32'h0000_0040, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0500, "collide_same");
        look(32'h0000_0040, "collide_next");

        // Sequential PC wraps, low bits ignored
        look(32'hFFFF_FFFC, "wrap");
        look(32'h0000_0183, "low_bits");

        // Random traffic over a small aliasing PC pool
        for (int i = 0; i < 400; i++) begin
            rpc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 63)) << 2)
                  | 32'($urandom_range(0, 3));
            rfp = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 63)) << 2);
            if ($urandom_range(0, 15) == 0) rfp = 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rfp = rpc;
            step(1'b0, rfp, 1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 2) != 0),
                 $urandom, "random");
        end

        // Mid-stream reset clears everything
        step(1'b1, 32'h0000_0180, 1'b1, 32'h0000_0180, 1'b1, 32'h0000_0900, "mid_reset");
        look(32'h0000_0180, "after_reset_a");
        look(32'h0000_0100, "after_reset_b");
        look(32'h0000_0040, "after_reset_c");

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
